// File: rtl/bch_error_locate_if.sv
// Chien-term / error-mask bundle between the Chien search and the error locator.
// The master drives first/chien/sigma_deg; the slave returns the err stream and frame status.
interface bch_error_locate_if #(
    parameter int M    = 4,
    parameter int T    = 2,
    parameter int BITS = 1
);
    localparam int CW = $clog2(T + 2);

    logic                      first;
    logic [(T+1)*M*BITS-1:0]   chien;
    logic [CW-1:0]             sigma_deg;
    logic                      valid;
    logic                      last;
    logic [BITS-1:0]           err;
    logic [CW-1:0]             err_count;
    logic                      done;
    logic                      uncorr;

    modport master (
        output first, chien, sigma_deg,
        input  valid, last, err, err_count, done, uncorr
    );

    modport slave (
        input  first, chien, sigma_deg,
        output valid, last, err, err_count, done, uncorr
    );
endinterface

// File: rtl/bch_error_locate.sv
// Locates BCH error positions from Chien terms, emits a masked err stream, counts errors, flags uncorrectable frames.
// Latency 1 cycle beat->err (2 with BCH_ERR_PIPE_EN defined); done one cycle after last.
// No backpressure: a frame is CYCLES back-to-back beats starting at first; first mid-frame aborts and restarts.
`ifndef BCH_SANE
`define BCH_SANE 32'h0402_0007
`endif
`ifndef BCH_M
`define BCH_M(p) (((p) >> 24) & 32'hff)
`endif
`ifndef BCH_T
`define BCH_T(p) (((p) >> 16) & 32'hff)
`endif
`ifndef BCH_DATA_BITS
`define BCH_DATA_BITS(p) ((p) & 32'hffff)
`endif

module bch_error_locate #(
    parameter logic [31:0] P    = `BCH_SANE,
    parameter int          BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    bch_error_locate_if.slave bus
);
    localparam int M         = int'(`BCH_M(P));
    localparam int T         = int'(`BCH_T(P));
    localparam int DATA_BITS = int'(`BCH_DATA_BITS(P));
    localparam int CYCLES    = (DATA_BITS + BITS - 1) / BITS;
    localparam int REM       = DATA_BITS - (CYCLES - 1) * BITS;
    localparam int CW        = $clog2(T + 2);
    localparam int BW        = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int LW        = (T + 1) * M;
    localparam logic [BW-1:0] LAST_BEAT = BW'(CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d, beat_idx;
    logic            in_vld, in_final;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // first restarts the beat count from any state, including mid-frame
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        in_vld   = bus.first || (state_q == RUN);
        beat_idx = bus.first ? '0 : beat_q;
        in_final = in_vld && (beat_idx == LAST_BEAT);
        if (in_vld) begin
            state_d = in_final ? DONE : RUN;
            beat_d  = in_final ? '0 : beat_idx + BW'(1);
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    logic [BITS-1:0][M-1:0] lane_sum;
    logic [BITS-1:0]        lane_live;

    always_comb begin
        lane_sum  = '0;
        lane_live = '0;
        for (int j = 0; j < BITS; j++) begin
            for (int i = 0; i <= T; i++)
                lane_sum[j] = lane_sum[j] ^ bus.chien[j*LW + i*M +: M];
            // final beat carries only REM data bits, in the top lanes
            lane_live[j] = !in_final || (j >= BITS - REM);
        end
    end

    logic [BITS-1:0] o_err_d;
    logic            o_vld_d, o_last_d, o_start_d;
    logic [CW-1:0]   o_deg_d;

`ifdef BCH_ERR_PIPE_EN
    logic [BITS-1:0][M-1:0] s1_sum;
    logic [BITS-1:0]        s1_live;
    logic                   s1_vld, s1_last, s1_start;
    logic [CW-1:0]          s1_deg;
    logic                   kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_sum   <= '0;
            s1_live  <= '0;
            s1_vld   <= 1'b0;
            s1_last  <= 1'b0;
            s1_start <= 1'b0;
            s1_deg   <= '0;
        end else begin
            s1_sum   <= lane_sum;
            s1_live  <= lane_live;
            s1_vld   <= in_vld;
            s1_last  <= in_final;
            s1_start <= bus.first;
            s1_deg   <= bus.sigma_deg;
        end
    end

    // an abort drops the old frame's beat still sitting in stage 1
    assign kill = bus.first && (state_q == RUN);

    always_comb begin
        o_vld_d   = s1_vld && !kill;
        o_last_d  = s1_last && !kill;
        o_start_d = s1_start && !kill;
        o_deg_d   = s1_deg;
        o_err_d   = '0;
        for (int j = 0; j < BITS; j++)
            o_err_d[j] = o_vld_d && s1_live[j] && (s1_sum[j] == '0);
    end
`else
    always_comb begin
        o_vld_d   = in_vld;
        o_last_d  = in_final;
        o_start_d = bus.first;
        o_deg_d   = bus.sigma_deg;
        o_err_d   = '0;
        for (int j = 0; j < BITS; j++)
            o_err_d[j] = in_vld && lane_live[j] && (lane_sum[j] == '0);
    end
`endif

    logic [BITS-1:0] err_q;
    logic            valid_q, last_q, done_q, uncorr_q;
    logic [CW-1:0]   cnt_q, cnt_d, deg_q;
    logic [15:0]     cnt_sum;

    always_comb begin
        cnt_sum = o_start_d ? 16'd0 : 16'(cnt_q);
        for (int j = 0; j < BITS; j++)
            cnt_sum = cnt_sum + 16'(o_err_d[j]);
        cnt_d = (cnt_sum > 16'(T + 1)) ? CW'(T + 1) : cnt_sum[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            uncorr_q <= 1'b0;
            cnt_q    <= '0;
            deg_q    <= '0;
        end else begin
            err_q   <= o_err_d;
            valid_q <= o_vld_d;
            last_q  <= o_last_d;
            done_q  <= last_q;
            if (o_start_d || o_vld_d)
                cnt_q <= cnt_d;
            if (o_start_d)
                deg_q <= o_deg_d;
            // verdict uses the finishing frame's count/degree even if a new frame starts now
            if (last_q)
                uncorr_q <= (cnt_q != deg_q) || (deg_q > CW'(T));
            else if (o_start_d)
                uncorr_q <= 1'b0;
        end
    end

    assign bus.valid     = valid_q;
    assign bus.last      = last_q;
    assign bus.err       = err_q;
    assign bus.err_count = cnt_q;
    assign bus.done      = done_q;
    assign bus.uncorr    = uncorr_q;
endmodule

// File: tb/tb_bch_error_locate.sv
// Directed bench for bch_error_locate on BCH(15,7,T=2): BITS=1 and BITS=4 instances, outputs logged per cycle.
module tb_bch_error_locate;
`ifdef BCH_ERR_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [11:0] Z1  = 12'h110;   // terms 0,1,1 -> XOR zero
    localparam logic [11:0] NZ1 = 12'h001;   // terms 1,0,0 -> XOR nonzero
    localparam int NLOG = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bch_error_locate_if #(.M(4), .T(2), .BITS(1)) bus1();
    bch_error_locate_if #(.M(4), .T(2), .BITS(4)) bus4();

    bch_error_locate #(.BITS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    bch_error_locate #(.BITS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       v1 [NLOG], l1 [NLOG], e1 [NLOG], d1 [NLOG], u1 [NLOG];
    logic [1:0] c1 [NLOG];
    logic       v4 [NLOG], l4 [NLOG], d4 [NLOG], u4 [NLOG];
    logic [3:0] e4 [NLOG];
    logic [1:0] c4 [NLOG];

    always @(negedge clk) begin
        if (cyc < NLOG) begin
            v1[cyc] = bus1.valid; l1[cyc] = bus1.last; e1[cyc] = bus1.err[0];
            d1[cyc] = bus1.done;  u1[cyc] = bus1.uncorr; c1[cyc] = bus1.err_count;
            v4[cyc] = bus4.valid; l4[cyc] = bus4.last; e4[cyc] = bus4.err;
            d4[cyc] = bus4.done;  u4[cyc] = bus4.uncorr; c4[cyc] = bus4.err_count;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus1.first = 1'b0; bus1.chien = NZ1;
        bus4.first = 1'b0; bus4.chien = {4{NZ1}};
        repeat (n) step();
    endtask

    task automatic beat1(input logic f, input logic z, input logic [1:0] deg);
        bus1.first = f; bus1.chien = z ? Z1 : NZ1; bus1.sigma_deg = deg;
        step();
    endtask

    task automatic frame1(input logic [6:0] zm, input logic [1:0] deg, output int s);
        s = cyc;
        for (int b = 0; b < 7; b++)
            beat1(b == 0, zm[b], deg);
    endtask

    task automatic beat4(input logic f, input logic [3:0] zm, input logic [1:0] deg);
        bus4.first = f; bus4.sigma_deg = deg;
        for (int j = 0; j < 4; j++)
            bus4.chien[j*12 +: 12] = zm[j] ? Z1 : NZ1;
        step();
    endtask

    // per-beat valid/err/last/count for a 7-beat BITS=1 frame, then done/uncorr
    task automatic check_frame1(input string tn, input int s, input logic [6:0] zm, input int eunc);
        int run;
        run = 0;
        for (int b = 0; b < 7; b++) begin
            run = run + int'(zm[b]);
            if (run > 3) run = 3;
            check($sformatf("%s valid b%0d", tn, b), int'(v1[s+b+LAT]), 1);
            check($sformatf("%s err b%0d", tn, b), int'(e1[s+b+LAT]), int'(zm[b]));
            check($sformatf("%s last b%0d", tn, b), int'(l1[s+b+LAT]), (b == 6) ? 1 : 0);
            check($sformatf("%s count b%0d", tn, b), int'(c1[s+b+LAT]), run);
        end
        check({tn, " done early"}, int'(d1[s+6+LAT]), 0);
        check({tn, " done"}, int'(d1[s+7+LAT]), 1);
        check({tn, " uncorr"}, int'(u1[s+7+LAT]), eunc);
    endtask

    int s, s2, sa, sb, ndone;

    initial begin
        reset = 1'b1;
        bus1.first = 1'b0; bus1.chien = NZ1; bus1.sigma_deg = 2'd0;
        bus4.first = 1'b0; bus4.chien = {4{NZ1}}; bus4.sigma_deg = 2'd0;
        repeat (3) step();
        reset = 1'b0;
        idle(2);
        check("reset valid", int'(v1[cyc-1]), 0);
        check("reset last", int'(l1[cyc-1]), 0);
        check("reset count", int'(c1[cyc-1]), 0);
        check("reset done", int'(d1[cyc-1]), 0);
        check("reset uncorr", int'(u1[cyc-1]), 0);
        check("reset valid4", int'(v4[cyc-1]), 0);

        // zero errors, deg 0
        frame1(7'b0000000, 2'd0, s);
        idle(4);
        check_frame1("t0", s, 7'b0000000, 0);
        check("t0 idle valid", int'(v1[s+7+LAT]), 0);

        // two roots on beats 1 and 5, deg 2
        frame1(7'b0100010, 2'd2, s);
        idle(4);
        check_frame1("t2", s, 7'b0100010, 0);

        // one root, deg 2 -> uncorrectable, held while idle
        frame1(7'b0001000, 2'd2, s);
        idle(5);
        check_frame1("t1", s, 7'b0001000, 1);
        check("t1 uncorr held", int'(u1[s+10+LAT]), 1);

        // four roots saturate the count at 3; deg 3 > T
        frame1(7'b0001111, 2'd3, s);
        idle(4);
        check_frame1("tsat", s, 7'b0001111, 1);

        // abort: first again on beat 3
        s = cyc;
        beat1(1'b1, 1'b1, 2'd1);
        beat1(1'b0, 1'b0, 2'd1);
        beat1(1'b0, 1'b1, 2'd1);
        frame1(7'b0000100, 2'd1, s2);
        idle(5);
        check("ab old b0 valid", int'(v1[s+LAT]), 1);
        check("ab old b1 count", int'(c1[s+1+LAT]), 1);
        check("ab old b2 valid", int'(v1[s+2+LAT]), (LAT == 2) ? 0 : 1);
        for (int k = s + LAT; k < s2 + LAT; k++) begin
            check($sformatf("ab no last c%0d", k - s), int'(l1[k]), 0);
            check($sformatf("ab no done c%0d", k - s), int'(d1[k]), 0);
        end
        check_frame1("ab new", s2, 7'b0000100, 0);

        // first on the DONE cycle: back-to-back frames
        frame1(7'b0010000, 2'd2, sa);
        frame1(7'b0000000, 2'd0, sb);
        idle(5);
        check("b2b gap", sb - sa, 7);
        check_frame1("b2b A", sa, 7'b0010000, 1);
        check_frame1("b2b B", sb, 7'b0000000, 0);

        // reset on beat 4
        s = cyc;
        beat1(1'b1, 1'b1, 2'd2);
        beat1(1'b0, 1'b0, 2'd2);
        beat1(1'b0, 1'b0, 2'd2);
        beat1(1'b0, 1'b0, 2'd2);
        reset = 1'b1;
        beat1(1'b0, 1'b0, 2'd2);
        reset = 1'b0;
        idle(12);
        check("rst pre count", int'(c1[s+4]), 1);
        check("rst valid", int'(v1[s+5]), 0);
        check("rst count", int'(c1[s+5]), 0);
        ndone = 0;
        for (int k = s + 5; k < s + 16; k++)
            ndone = ndone + int'(d1[k]);
        check("rst no done", ndone, 0);

        // BITS=4: non-final beat keeps lane 0; final beat masks it
        s = cyc;
        beat4(1'b1, 4'b1001, 2'd2);
        beat4(1'b0, 4'b0001, 2'd2);
        idle(4);
        check("w4a b0 valid", int'(v4[s+LAT]), 1);
        check("w4a b0 err", int'(e4[s+LAT]), 4'b1001);
        check("w4a b0 last", int'(l4[s+LAT]), 0);
        check("w4a b1 err", int'(e4[s+1+LAT]), 4'b0000);
        check("w4a b1 last", int'(l4[s+1+LAT]), 1);
        check("w4a count", int'(c4[s+1+LAT]), 2);
        check("w4a done", int'(d4[s+2+LAT]), 1);
        check("w4a uncorr", int'(u4[s+2+LAT]), 0);

        s = cyc;
        beat4(1'b1, 4'b0000, 2'd2);
        beat4(1'b0, 4'b1111, 2'd2);
        idle(4);
        check("w4b b0 err", int'(e4[s+LAT]), 4'b0000);
        check("w4b b1 err", int'(e4[s+1+LAT]), 4'b1110);
        check("w4b b1 valid", int'(v4[s+1+LAT]), 1);
        check("w4b count", int'(c4[s+1+LAT]), 3);
        check("w4b after valid", int'(v4[s+2+LAT]), 0);
        check("w4b done", int'(d4[s+2+LAT]), 1);
        check("w4b uncorr", int'(u4[s+2+LAT]), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
